// File: rtl/fft_radix2_stage.sv
// fft_radix2_stage -- one in-place radix-2 DIT butterfly stage.
//
// A frame of N = 2^N_LOG2 complex samples is loaded into a single frame
// buffer. LANES butterflies are then applied per cycle for N/(2*LANES)
// cycles. After that the buffer is presented downstream until it is
// accepted. The butterfly and twiddle indexes come from the cycle counter.
// Products are rounded half-up and results are saturated. A sticky flag
// records any saturation in the frame.
//
// Optional feature: define FFT_STAGE_SCALE_EN to halve every butterfly
// output, rounded half-up, before saturation.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   in_valid / in_ready     input frame handshake
//   in_re / in_im           N packed signed samples, element i at [i*DATA_W +: DATA_W]
//   out_valid / out_ready   output frame handshake
//   out_re / out_im         frame buffer contents, meaningful while out_valid=1
//   out_ovf                 saturation happened in the presented frame
//   tw_addr                 twiddle index k per lane, N_LOG2-1 bits per lane
//   tw_re / tw_im           cos / -sin of 2*pi*k/N in Q(COEF_FRAC), returned in the same cycle
module fft_radix2_stage #(
  parameter int N_LOG2    = 3,
  parameter int STAGE     = 0,
  parameter int DATA_W    = 16,
  parameter int COEF_FRAC = 8,
  parameter int LANES     = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [(1<<N_LOG2)*DATA_W-1:0]        in_re,
  input  logic [(1<<N_LOG2)*DATA_W-1:0]        in_im,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [(1<<N_LOG2)*DATA_W-1:0]        out_re,
  output logic [(1<<N_LOG2)*DATA_W-1:0]        out_im,
  output logic                                 out_ovf,
  output logic [LANES*(N_LOG2-1)-1:0]          tw_addr,
  input  logic [LANES*(COEF_FRAC+2)-1:0]       tw_re,
  input  logic [LANES*(COEF_FRAC+2)-1:0]       tw_im
);

  localparam int N      = 1 << N_LOG2;
  localparam int COEF_W = COEF_FRAC + 2;
  localparam int TW_W   = N_LOG2 - 1;
  // Internal arithmetic width. It holds the sum of two full products plus
  // the rounding term without wrapping.
  localparam int PW     = DATA_W + COEF_W + 2;
  localparam logic [N_LOG2-1:0] CNT_LAST = N_LOG2'(N / (2 * LANES) - 1);

  localparam logic signed [PW-1:0] ONE  = PW'(1);
  localparam logic signed [PW-1:0] RND  = PW'(1) << (COEF_FRAC - 1);
  localparam logic signed [PW-1:0] SMAX = (PW'(1) << (DATA_W - 1)) - PW'(1);
  localparam logic signed [PW-1:0] SMIN = -(PW'(1) << (DATA_W - 1));

  typedef enum logic [1:0] {ST_IDLE, ST_COMPUTE, ST_HOLD} state_t;

  state_t              state_q, state_d;
  logic [N_LOG2-1:0]   counter_q, counter_d;
  logic                ovf_q, ovf_d;
  logic [DATA_W-1:0]   re_q [0:N-1];
  logic [DATA_W-1:0]   re_d [0:N-1];
  logic [DATA_W-1:0]   im_q [0:N-1];
  logic [DATA_W-1:0]   im_d [0:N-1];

  // Per-lane results, flattened so that each lane drives its own slice.
  logic [LANES*N_LOG2-1:0] lane_ia, lane_ib;
  logic [LANES*DATA_W-1:0] lane_a_re, lane_a_im, lane_b_re, lane_b_im;
  logic [LANES-1:0]        lane_ovf;

  function automatic logic [DATA_W-1:0] sat(input logic signed [PW-1:0] v);
    if (v > SMAX) return SMAX[DATA_W-1:0];
    if (v < SMIN) return SMIN[DATA_W-1:0];
    return v[DATA_W-1:0];
  endfunction

  function automatic logic is_sat(input logic signed [PW-1:0] v);
    return (v > SMAX) || (v < SMIN);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [N_LOG2-1:0]        j, pos, grp, ia, ib;
      logic signed [DATA_W-1:0] ar, ai, br, bi;
      logic signed [COEF_W-1:0] wr, wi;
      logic signed [PW-1:0]     pr, pi, qr, qi;
      logic signed [PW-1:0]     sa_re, sa_im, sb_re, sb_im;
      logic signed [PW-1:0]     fa_re, fa_im, fb_re, fb_im;

      // Butterfly j splits into a position within its group and a group number.
      assign j   = N_LOG2'(counter_q * LANES + gi);
      assign pos = j & N_LOG2'((1 << STAGE) - 1);
      assign grp = j >> STAGE;
      assign ia  = (grp << (STAGE + 1)) | pos;
      assign ib  = ia | N_LOG2'(1 << STAGE);

      assign tw_addr[gi*TW_W +: TW_W] = TW_W'(pos << (N_LOG2 - 1 - STAGE));

      assign ar = re_q[ia];
      assign ai = im_q[ia];
      assign br = re_q[ib];
      assign bi = im_q[ib];
      assign wr = tw_re[gi*COEF_W +: COEF_W];
      assign wi = tw_im[gi*COEF_W +: COEF_W];

      assign pr = (PW'(br) * PW'(wr)) - (PW'(bi) * PW'(wi));
      assign pi = (PW'(br) * PW'(wi)) + (PW'(bi) * PW'(wr));
      assign qr = (pr + RND) >>> COEF_FRAC;
      assign qi = (pi + RND) >>> COEF_FRAC;

      assign sa_re = PW'(ar) + qr;
      assign sa_im = PW'(ai) + qi;
      assign sb_re = PW'(ar) - qr;
      assign sb_im = PW'(ai) - qi;

`ifdef FFT_STAGE_SCALE_EN
      assign fa_re = (sa_re + ONE) >>> 1;
      assign fa_im = (sa_im + ONE) >>> 1;
      assign fb_re = (sb_re + ONE) >>> 1;
      assign fb_im = (sb_im + ONE) >>> 1;
`else
      assign fa_re = sa_re;
      assign fa_im = sa_im;
      assign fb_re = sb_re;
      assign fb_im = sb_im;
`endif

      assign lane_ia[gi*N_LOG2 +: N_LOG2]   = ia;
      assign lane_ib[gi*N_LOG2 +: N_LOG2]   = ib;
      assign lane_a_re[gi*DATA_W +: DATA_W] = sat(fa_re);
      assign lane_a_im[gi*DATA_W +: DATA_W] = sat(fa_im);
      assign lane_b_re[gi*DATA_W +: DATA_W] = sat(fb_re);
      assign lane_b_im[gi*DATA_W +: DATA_W] = sat(fb_im);
      assign lane_ovf[gi] = is_sat(fa_re) | is_sat(fa_im) | is_sat(fb_re) | is_sat(fb_im);
    end

    for (gi = 0; gi < N; gi++) begin : g_out
      assign out_re[gi*DATA_W +: DATA_W] = re_q[gi];
      assign out_im[gi*DATA_W +: DATA_W] = im_q[gi];
    end
  endgenerate

  assign out_ovf = ovf_q;

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    ovf_d     = ovf_q;
    re_d      = re_q;
    im_d      = im_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
      end
      ST_COMPUTE: begin
        // Lanes touch disjoint elements, so the write order does not matter.
        for (int l = 0; l < LANES; l++) begin
          re_d[lane_ia[l*N_LOG2 +: N_LOG2]] = lane_a_re[l*DATA_W +: DATA_W];
          im_d[lane_ia[l*N_LOG2 +: N_LOG2]] = lane_a_im[l*DATA_W +: DATA_W];
          re_d[lane_ib[l*N_LOG2 +: N_LOG2]] = lane_b_re[l*DATA_W +: DATA_W];
          im_d[lane_ib[l*N_LOG2 +: N_LOG2]] = lane_b_im[l*DATA_W +: DATA_W];
        end
        ovf_d = ovf_q | (|lane_ovf);
        if (counter_q == CNT_LAST) begin
          state_d = ST_HOLD;
        end else begin
          counter_d = counter_q + N_LOG2'(1);
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready && !in_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // In IDLE, or when the held frame is handed off, a new frame loads in the same cycle.
    if (in_ready && in_valid) begin
      for (int i = 0; i < N; i++) begin
        re_d[i] = in_re[i*DATA_W +: DATA_W];
        im_d[i] = in_im[i*DATA_W +: DATA_W];
      end
      ovf_d     = 1'b0;
      counter_d = '0;
      state_d   = ST_COMPUTE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      counter_q <= '0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < N; i++) begin
        re_q[i] <= '0;
        im_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      ovf_q     <= ovf_d;
      re_q      <= re_d;
      im_q      <= im_d;
    end
  end

endmodule

// File: tb/tb_fft_radix2_stage.sv
// tb_fft_radix2_stage -- four stage instances (stage/lanes = 0/1, 0/2, 2/1,
// 1/2) for N=8, DATA_W=16, COEF_FRAC=8. All four share the input stream.
// Every instance is checked against a butterfly model built from the group
// and span view of a DIT stage.
module tb_fft_radix2_stage;

  localparam int N  = 8;
  localparam int DW = 16;
`ifdef FFT_STAGE_SCALE_EN
  localparam bit SCALE = 1'b1;
`else
  localparam bit SCALE = 1'b0;
`endif

  localparam int COS_I  [4] = '{256, 181, 0, -181};
  localparam int MSIN_I [4] = '{0, -181, -256, -181};
  localparam int STG    [4] = '{0, 0, 2, 1};
  localparam int LN     [4] = '{1, 2, 1, 2};

  logic clk = 1'b0;
  logic reset, in_valid, out_ready;
  logic [N*DW-1:0] in_re, in_im;
  logic [3:0] in_ready_v, out_valid_v, ovf_v;
  logic [N*DW-1:0] o_re [4];
  logic [N*DW-1:0] o_im [4];
  logic [1:0]  ta0, ta2;
  logic [3:0]  ta1, ta3;
  logic [9:0]  tr0, ti0, tr2, ti2;
  logic [19:0] tr1, ti1, tr3, ti3;

  bit ovr_en;
  int ovr_re_i, ovr_im_i;
  int stim_re [N];
  int stim_im [N];
  longint exp_re [4][N];
  longint exp_im [4][N];
  longint exp_ovf [4];
  int total, bad;
  bit tw1_seen;

  always #5 clk = ~clk;

  fft_radix2_stage #(.N_LOG2(3), .STAGE(0), .DATA_W(16), .COEF_FRAC(8), .LANES(1)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid_v[0]), .out_ready(out_ready),
    .out_re(o_re[0]), .out_im(o_im[0]), .out_ovf(ovf_v[0]),
    .tw_addr(ta0), .tw_re(tr0), .tw_im(ti0));
  fft_radix2_stage #(.N_LOG2(3), .STAGE(0), .DATA_W(16), .COEF_FRAC(8), .LANES(2)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid_v[1]), .out_ready(out_ready),
    .out_re(o_re[1]), .out_im(o_im[1]), .out_ovf(ovf_v[1]),
    .tw_addr(ta1), .tw_re(tr1), .tw_im(ti1));
  fft_radix2_stage #(.N_LOG2(3), .STAGE(2), .DATA_W(16), .COEF_FRAC(8), .LANES(1)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_v[2]),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid_v[2]), .out_ready(out_ready),
    .out_re(o_re[2]), .out_im(o_im[2]), .out_ovf(ovf_v[2]),
    .tw_addr(ta2), .tw_re(tr2), .tw_im(ti2));
  fft_radix2_stage #(.N_LOG2(3), .STAGE(1), .DATA_W(16), .COEF_FRAC(8), .LANES(2)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_v[3]),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid_v[3]), .out_ready(out_ready),
    .out_re(o_re[3]), .out_im(o_im[3]), .out_ovf(ovf_v[3]),
    .tw_addr(ta3), .tw_re(tr3), .tw_im(ti3));

  // Twiddle source: the Q8 table for N=8, or a fixed override coefficient.
  always_comb begin
    if (ovr_en) begin
      tr0 = 10'(ovr_re_i);       ti0 = 10'(ovr_im_i);
      tr2 = 10'(ovr_re_i);       ti2 = 10'(ovr_im_i);
      tr1 = {2{10'(ovr_re_i)}};  ti1 = {2{10'(ovr_im_i)}};
      tr3 = {2{10'(ovr_re_i)}};  ti3 = {2{10'(ovr_im_i)}};
    end else begin
      tr0 = 10'(COS_I[ta0]);     ti0 = 10'(MSIN_I[ta0]);
      tr2 = 10'(COS_I[ta2]);     ti2 = 10'(MSIN_I[ta2]);
      tr1 = {10'(COS_I[ta1[3:2]]), 10'(COS_I[ta1[1:0]])};
      ti1 = {10'(MSIN_I[ta1[3:2]]), 10'(MSIN_I[ta1[1:0]])};
      tr3 = {10'(COS_I[ta3[3:2]]), 10'(COS_I[ta3[1:0]])};
      ti3 = {10'(MSIN_I[ta3[3:2]]), 10'(MSIN_I[ta3[1:0]])};
    end
  end

  task automatic check_val(input string tag, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  function automatic longint get_re(input int d, input int i);
    logic signed [DW-1:0] v;
    v = o_re[d][i*DW +: DW];
    return longint'(v);
  endfunction

  function automatic longint get_im(input int d, input int i);
    logic signed [DW-1:0] v;
    v = o_im[d][i*DW +: DW];
    return longint'(v);
  endfunction

  function automatic longint scaled(input longint v);
    return SCALE ? ((v + 1) >>> 1) : v;
  endfunction

  function automatic longint clamp(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Model of one DIT stage: groups of 2*span elements. Each group pairs
  // element p with element p+span using twiddle k = p*N/(2*span).
  task automatic model(input int d);
    int span;
    span = 1 << STG[d];
    exp_ovf[d] = 0;
    for (int i = 0; i < N; i++) begin
      exp_re[d][i] = stim_re[i];
      exp_im[d][i] = stim_im[i];
    end
    for (int st = 0; st < N; st += 2 * span) begin
      for (int p = 0; p < span; p++) begin
        int a, b, k;
        longint wr, wi, pr, pi;
        longint v [4];
        a = st + p;
        b = a + span;
        k = p * (N / (2 * span));
        wr = ovr_en ? ovr_re_i : COS_I[k];
        wi = ovr_en ? ovr_im_i : MSIN_I[k];
        pr = longint'(stim_re[b]) * wr - longint'(stim_im[b]) * wi;
        pi = longint'(stim_re[b]) * wi + longint'(stim_im[b]) * wr;
        pr = (pr + 128) >>> 8;
        pi = (pi + 128) >>> 8;
        v[0] = scaled(stim_re[a] + pr);
        v[1] = scaled(stim_im[a] + pi);
        v[2] = scaled(stim_re[a] - pr);
        v[3] = scaled(stim_im[a] - pi);
        for (int q = 0; q < 4; q++)
          if (clamp(v[q]) != v[q]) exp_ovf[d] = 1;
        exp_re[d][a] = clamp(v[0]);
        exp_im[d][a] = clamp(v[1]);
        exp_re[d][b] = clamp(v[2]);
        exp_im[d][b] = clamp(v[3]);
      end
    end
  endtask

  function automatic bit frame_matches(input int d);
    for (int i = 0; i < N; i++)
      if (get_re(d, i) != exp_re[d][i] || get_im(d, i) != exp_im[d][i]) return 1'b0;
    return ovf_v[d] == exp_ovf[d][0];
  endfunction

  task automatic drive_stim();
    for (int i = 0; i < N; i++) begin
      in_re[i*DW +: DW] = 16'(stim_re[i]);
      in_im[i*DW +: DW] = 16'(stim_im[i]);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < N; i++) begin
      stim_re[i] = 0;
      stim_im[i] = 0;
    end
  endtask

  task automatic rand_stim(input bit full);
    for (int i = 0; i < N; i++) begin
      if (full) begin
        stim_re[i] = int'($signed(16'($urandom)));
        stim_im[i] = int'($signed(16'($urandom)));
      end else begin
        stim_re[i] = int'($urandom_range(0, 4000)) - 2000;
        stim_im[i] = int'($urandom_range(0, 4000)) - 2000;
      end
    end
  endtask

  // Offer the current stimulus (from IDLE, or as a handoff from HOLD). Then
  // wait for every instance to present it, check latency and contents, and
  // keep it held for hold_cycles more cycles.
  task automatic run_frame(input bit from_hold, input int hold_cycles);
    bit [3:0] seen;
    int lat [4];
    int good [4];
    @(negedge clk);
    drive_stim();
    in_valid  = 1'b1;
    out_ready = from_hold;
    #1;
    for (int d = 0; d < 4; d++) check_val($sformatf("d%0d in_ready at accept", d), in_ready_v[d], 1);
    for (int d = 0; d < 4; d++) model(d);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    seen = '0;
    tw1_seen = 1'b0;
    for (int d = 0; d < 4; d++) lat[d] = 0;
    for (int k = 1; k <= 20 && seen != 4'hF; k++) begin
      @(posedge clk);
      #1;
      if (!seen[2] && ta2 == 2'd1) tw1_seen = 1'b1;
      for (int d = 0; d < 4; d++)
        if (out_valid_v[d] && !seen[d]) begin
          seen[d] = 1'b1;
          lat[d]  = k;
        end
    end
    for (int d = 0; d < 4; d++) begin
      check_val($sformatf("d%0d latency", d), lat[d], N / (2 * LN[d]));
      for (int i = 0; i < N; i++) begin
        check_val($sformatf("d%0d re[%0d]", d, i), get_re(d, i), exp_re[d][i]);
        check_val($sformatf("d%0d im[%0d]", d, i), get_im(d, i), exp_im[d][i]);
      end
      check_val($sformatf("d%0d ovf", d), ovf_v[d], exp_ovf[d]);
      good[d] = 0;
    end
    for (int c = 0; c < hold_cycles; c++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 4; d++)
        if (out_valid_v[d] && !in_ready_v[d] && frame_matches(d)) good[d]++;
    end
    if (hold_cycles > 0)
      for (int d = 0; d < 4; d++) check_val($sformatf("d%0d stable hold", d), good[d], hold_cycles);
  endtask

  task automatic release_idle();
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) check_val($sformatf("d%0d in_ready follows out_ready", d), in_ready_v[d], 1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int d = 0; d < 4; d++) begin
      check_val($sformatf("d%0d out_valid after handoff", d), out_valid_v[d], 0);
      check_val($sformatf("d%0d idle in_ready", d), in_ready_v[d], 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit in_hold;
    bit any_out;
    total = 0;
    bad = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    ovr_en = 1'b0;
    ovr_re_i = 0;
    ovr_im_i = 0;
    in_re = '0;
    in_im = '0;
    clear_stim();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      check_val($sformatf("d%0d reset out_valid", d), out_valid_v[d], 0);
      check_val($sformatf("d%0d reset in_ready", d), in_ready_v[d], 1);
      check_val($sformatf("d%0d reset ovf", d), ovf_v[d], 0);
    end
    check_val("reset buffer", longint'(o_re[0] == '0 && o_im[0] == '0), 1);

    // Impulse at element 0.
    clear_stim();
    stim_re[0] = 256;
    run_frame(1'b0, 0);
    check_val("impulse d0 re[1]", get_re(0, 1), SCALE ? 128 : 256);
    check_val("impulse d1 re[1]", get_re(1, 1), SCALE ? 128 : 256);
    release_idle();

    // Twiddle k=1 seen by the span-4 stage.
    clear_stim();
    stim_re[5] = 256;
    run_frame(1'b0, 0);
    check_val("d2 tw_addr 1 seen", tw1_seen, 1);
    check_val("twiddle d2 re[5]", get_re(2, 5), SCALE ? -90 : -181);
    check_val("twiddle d2 im[1]", get_im(2, 1), SCALE ? -90 : -181);
    release_idle();

    // Saturation, then a clean frame that is handed off back-to-back.
    clear_stim();
    stim_re[0] = 32767;
    stim_re[1] = 32767;
    run_frame(1'b0, 0);
    check_val("sat d0 re[0]", get_re(0, 0), 32767);
    check_val("sat d0 ovf", ovf_v[0], SCALE ? 0 : 1);
    rand_stim(1'b0);
    run_frame(1'b1, 0);
    check_val("clean d0 ovf", ovf_v[0], 0);
    release_idle();

    // Backpressure for 10 cycles, then a handoff together with a new frame.
    rand_stim(1'b1);
    run_frame(1'b0, 10);
    rand_stim(1'b0);
    run_frame(1'b1, 0);
    release_idle();

    // Reset while the single-lane instances are at counter 2.
    rand_stim(1'b0);
    @(negedge clk);
    drive_stim();
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int d = 0; d < 4; d++) begin
      check_val($sformatf("d%0d out_valid after reset", d), out_valid_v[d], 0);
      check_val($sformatf("d%0d in_ready after reset", d), in_ready_v[d], 1);
    end
    any_out = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (out_valid_v != 4'b0) any_out = 1'b1;
    end
    check_val("no output for reset frame", any_out, 0);

    // Rounding with an override coefficient of 0.5.
    ovr_en = 1'b1;
    ovr_re_i = 128;
    ovr_im_i = 0;
    clear_stim();
    stim_re[1] = 1;
    run_frame(1'b0, 0);
    check_val("round d0 re[0]", get_re(0, 0), 1);
    check_val("round d0 re[1]", get_re(0, 1), SCALE ? 0 : -1);
    release_idle();
    ovr_en = 1'b0;
    clear_stim();
    stim_re[0] = 256;
    stim_re[1] = 256;
    run_frame(1'b0, 0);
    check_val("scale d0 re[0]", get_re(0, 0), SCALE ? 256 : 512);
    check_val("scale d0 re[1]", get_re(0, 1), 0);
    release_idle();

    // Random frames with a random mix of idle starts and back-to-back handoffs.
    in_hold = 1'b0;
    for (int f = 0; f < 24; f++) begin
      rand_stim(1'($urandom_range(0, 1)));
      if (in_hold && $urandom_range(0, 1) == 1) begin
        run_frame(1'b1, int'($urandom_range(0, 3)));
      end else begin
        if (in_hold) release_idle();
        run_frame(1'b0, int'($urandom_range(0, 3)));
      end
      in_hold = 1'b1;
    end
    release_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
